// File: rtl/prime_scan_ctrl.sv
// Range scanner that feeds candidates lo..hi to an external is_prime checker
// and streams the primes found through a small FIFO with valid/ready back-pressure.
module prime_scan_ctrl #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cand,
  input  logic             cand_is_prime,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic [WIDTH-1:0] prime_data,
  output logic [WIDTH-1:0] prime_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FILL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FILL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FILL_ZERO = (AW+1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             pop_s, push_s, push_ok_s, flush_s, drained_s;

  // Sequencer next-state: candidate stepping, stall on full FIFO, abort priority.
  always_comb begin
    pop_s     = valid_q & prime_ready;
    push_ok_s = (fill_q != FILL_FULL) | pop_s;
    // DRAIN never pushes, so the FIFO is empty next cycle if this pop takes the last entry
    drained_s = (fill_q == FILL_ZERO) | ((fill_q == FILL_ONE) & pop_s);
    push_s    = 1'b0;
    flush_s   = 1'b0;
    state_d   = state_q;
    cand_d    = cand_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lo_d    = lo;
          hi_d    = hi;
          cand_d  = lo;
          count_d = {WIDTH{1'b0}};
          state_d = (lo > hi) ? ST_DONE : ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          flush_s = 1'b1;
          state_d = ST_IDLE;
        end else if (cand_is_prime && !push_ok_s) begin
          state_d = ST_SCAN;
        end else begin
          push_s  = cand_is_prime;
          count_d = count_q + WIDTH'(cand_is_prime);
          // compare before increment so hi at the top of the range never wraps
          if (cand_q == hi_q) begin
            state_d = ST_DRAIN;
          end else begin
            cand_d = cand_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush_s = 1'b1;
          state_d = ST_IDLE;
        end else if (drained_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO next-state plus registered output images.
  always_comb begin
    mem_d = mem_q;
    if (flush_s) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      fill_d   = FILL_ZERO;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = cand_q;
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      wr_ptr_d = wr_ptr_q + AW'(push_s);
      rd_ptr_d = rd_ptr_q + AW'(pop_s);
      fill_d   = fill_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
    data_d  = mem_d[rd_ptr_d];
    valid_d = (fill_d != FILL_ZERO);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cand_q   <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      count_q  <= {WIDTH{1'b0}};
      data_q   <= {WIDTH{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      fill_q   <= FILL_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      count_q  <= count_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cand        = cand_q;
  assign prime_valid = valid_q;
  assign prime_data  = data_q;
  assign prime_count = count_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Scoreboard bench: expected primes queued per scan, popped by a monitor on each handshake.
module tb_prime_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, prime_ready;
  logic [31:0] lo_i, hi_i;
  logic        busy, done, cand_is_prime, prime_valid;
  logic [31:0] cand, prime_data, prime_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic bit is_prime_f(input longint unsigned n);
    if (n < 2) return 1'b0;
    if (n % 2 == 0) return (n == 2);
    for (longint unsigned d = 3; d * d <= n; d += 2)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  assign cand_is_prime = is_prime_f(64'(cand));

  prime_scan_ctrl #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .lo(lo_i), .hi(hi_i), .busy(busy), .done(done), .cand(cand),
    .cand_is_prime(cand_is_prime), .prime_valid(prime_valid),
    .prime_ready(prime_ready), .prime_data(prime_data), .prime_count(prime_count)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n && prime_valid && prime_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_prime: got %0d expected none", prime_data);
      end else begin
        if (prime_data !== exp_q[0]) begin
          bad++;
          $display("FAIL prime_order: got %0d expected %0d", prime_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // mode 0: ready held 1; mode 1: random ready; mode 2: ready 0 for 20 cycles then 1
  task automatic scan(input logic [31:0] l, input logic [31:0] h, input int mode, input int abort_at);
    int exp_n = 0;
    int busy_cyc = 0;
    int done_n = 0;
    bit finished = 1'b0;
    longint unsigned cnt_done = 0, cand_done = 0, cnt_before = 0;
    longint unsigned exp_busy = (l > h) ? 1 : (64'(h) - 64'(l) + 3);
    for (longint unsigned v = 64'(l); v <= 64'(h); v++)
      if (is_prime_f(v)) begin
        exp_q.push_back(v[31:0]);
        exp_n++;
      end
    prime_ready = (mode != 2);
    @(posedge clk); #1;
    lo_i = l; hi_i = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lo_i = $urandom; hi_i = $urandom;
    chk("start_count_clear", prime_count, 0);
    chk("start_busy", busy, 1);
    for (int c = 0; c < 20000; c++) begin
      if (mode == 2 && c == 20) begin
        chk("stall_cand", cand, 11);
        chk("stall_count", prime_count, 4);
        chk("stall_valid", prime_valid, 1);
      end
      case (mode)
        0: prime_ready = 1'b1;
        1: prime_ready = 1'($urandom % 2);
        default: prime_ready = (c >= 20);
      endcase
      abort = (c == abort_at);
      start = (abort_at >= 0 && c == 10);
      #3;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (done) begin
        done_n++;
        cnt_done = prime_count;
        cand_done = cand;
      end
      cnt_before = prime_count;
      @(posedge clk); #1;
      if (c == abort_at) begin
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", prime_valid, 0);
        chk("abort_count_frozen", prime_count, cnt_before);
        chk("abort_no_done", done, 0);
        exp_q.delete();
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("scan_terminated", finished, 1);
    if (abort_at < 0) begin
      chk("done_pulses", done_n, 1);
      chk("count_at_done", cnt_done, exp_n);
      chk("cand_at_done", cand_done, (l > h) ? l : h);
      if (mode == 0) chk("busy_cycles", busy_cyc, exp_busy);
    end else begin
      chk("abort_done_pulses", done_n, 0);
    end
    chk("stream_complete", exp_q.size(), 0);
    chk("end_valid", prime_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; prime_ready = 1'b0;
    lo_i = 32'd0; hi_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", prime_valid, 0);
    chk("rst_cand", cand, 0);
    chk("rst_count", prime_count, 0);
    chk("rst_data", prime_data, 0);
    rst_n = 1'b1;

    scan(32'd2, 32'd10, 0, -1);
    scan(32'd0, 32'd1, 0, -1);
    scan(32'd20, 32'd10, 0, -1);
    scan(32'd2, 32'd30, 2, -1);
    scan(32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, -1);
    scan(32'd2, 32'd1000, 1, 50);
    scan(32'd2, 32'd10, 0, -1);

    // reset in the middle of a stalled scan
    prime_ready = 1'b0;
    @(posedge clk); #1;
    lo_i = 32'd2; hi_i = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_valid", prime_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cand", cand, 0);
    chk("midrst_count", prime_count, 0);
    chk("midrst_valid", prime_valid, 0);
    chk("midrst_data", prime_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      logic [31:0] l, h;
      l = $urandom_range(0, 300);
      h = (i == 0) ? l - 32'd1 : l + $urandom_range(0, 50);
      if (i == 0 && l == 32'd0) h = 32'd0;
      scan(l, h, int'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
